// File: rtl/trng_entropy_collector_pkg.sv
// Shared TRNG definitions: collector FSM encoding and datapath block width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trng_entropy_collector_pkg;

  // Must match the hashing datapath data_in width.
  localparam int TRNG_BLOCK_W    = 512;
  // Default repetition-count cutoff for the raw noise health test.
  localparam int TRNG_RCT_CUTOFF = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2,
    ST_FAIL    = 2'd3
  } trng_state_e;

endpackage

// File: rtl/trng_entropy_collector_if.sv
// Block handoff bundle between the entropy collector and the TRNG controller.
// Latency: n/a (wires only).
// Backpressure: block_data/block_valid hold until block_ready is seen with valid.
// Ports: block_data (block payload), block_valid (block offered), block_ready (consumer accepts).
interface trng_entropy_collector_if
  import trng_entropy_collector_pkg::*;
#(
  parameter int BLOCK_W = TRNG_BLOCK_W
) ();

  logic [BLOCK_W-1:0] block_data;
  logic               block_valid;
  logic               block_ready;

  modport master (output block_data, output block_valid, input block_ready);
  modport slave  (input block_data, input block_valid, output block_ready);

endinterface

// File: rtl/trng_entropy_collector_rct_monitor.sv
// Repetition-count health test on strobed raw noise samples.
// Latency: fail_pulse is combinational in the strobe cycle that reaches CUTOFF; count is registered.
// Backpressure: none; evaluates only when strobe=1, clear has priority over strobe.
// Ports: clk, Reset (sync, active-high), strobe, raw_bit, clear, fail_pulse, count.
module trng_rct_monitor
  import trng_entropy_collector_pkg::*;
#(
  parameter int CUTOFF = TRNG_RCT_CUTOFF
) (
  input  logic                        clk,
  input  logic                        Reset,
  input  logic                        strobe,
  input  logic                        raw_bit,
  input  logic                        clear,
  output logic                        fail_pulse,
  output logic [$clog2(CUTOFF+1)-1:0] count
);

  localparam int            CW  = $clog2(CUTOFF + 1);
  localparam logic [CW-1:0] CUT = CW'(CUTOFF);

  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    fail_pulse = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (strobe) begin
      prev_d = raw_bit;
      // A zero count means no valid previous sample, so the run restarts at 1.
      if ((cnt_q != '0) && (raw_bit == prev_q)) begin
        if (cnt_q != CUT) cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = CW'(1);
      end
      fail_pulse = (cnt_d == CUT);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/trng_entropy_collector.sv
// TRNG entropy collector: decimates raw noise, von Neumann debiases it and packs BLOCK_W bits per block.
// Latency: block_valid rises on the same edge that shifts in the last bit; bit_count updates with each emitted bit.
// Backpressure: in FULL sampling freezes and block_data holds until block_valid & block_ready.
// Ports: clk, Reset (sync, active-high), enable, raw_bit, clear_fail, health_fail (sticky),
//        bit_count (bits in current block), blk (master side: block_data/block_valid/block_ready).
module trng_entropy_collector
  import trng_entropy_collector_pkg::*;
#(
  parameter int BLOCK_W    = TRNG_BLOCK_W,
  parameter int SAMPLE_DIV = 4,
  parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       enable,
  input  logic                       raw_bit,
  input  logic                       clear_fail,
  output logic                       health_fail,
  output logic [$clog2(BLOCK_W):0]   bit_count,
  trng_entropy_collector_if.master   blk
);

  localparam int               CNT_W    = $clog2(BLOCK_W) + 1;
  localparam int               DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_W - 1);
  localparam int               RCT_CW   = $clog2(RCT_CUTOFF + 1);

  trng_state_e        state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               pair_q, pair_d;
  logic               first_q, first_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fail_q, fail_d;

  logic               strobe;
  logic               rct_fail;
  logic [RCT_CW-1:0]  rct_count;

  // The divider only runs in COLLECT, so strobes are implicitly frozen in FULL/FAIL/IDLE.
  assign strobe = (state_q == ST_COLLECT) && (div_q == DIV_MAX);

  trng_rct_monitor #(
    .CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk        (clk),
    .Reset      (Reset),
    .strobe     (strobe),
    .raw_bit    (raw_bit),
    .clear      (clear_fail),
    .fail_pulse (rct_fail),
    .count      (rct_count)
  );

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    pair_d  = pair_q;
    first_d = first_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_COLLECT;
          div_d   = '0;
        end
      end

      ST_COLLECT: begin
        // A health failure beats a simultaneous enable drop; both discard the partial block.
        if (rct_fail) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          cnt_d   = '0;
          pair_d  = 1'b0;
          div_d   = '0;
        end else if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pair_d  = 1'b0;
          div_d   = '0;
        end else begin
          div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
          if (strobe) begin
            if (!pair_q) begin
              first_d = raw_bit;
              pair_d  = 1'b1;
            end else begin
              pair_d = 1'b0;
              // 10 -> 1, 01 -> 0: the emitted bit equals the first sample of the pair.
              if (first_q != raw_bit) begin
                data_d = {data_q[BLOCK_W-2:0], first_q};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FULL;
              end
            end
          end
        end
      end

      ST_FULL: begin
        if (blk.block_ready) begin
          cnt_d   = '0;
          pair_d  = 1'b0;
          div_d   = '0;
          state_d = enable ? ST_COLLECT : ST_IDLE;
        end
      end

      ST_FAIL: begin
        if (clear_fail) begin
          fail_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      pair_q  <= 1'b0;
      first_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pair_q  <= pair_d;
      first_q <= first_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
    end
  end

  assign blk.block_data  = data_q;
  assign blk.block_valid = (state_q == ST_FULL);
  assign bit_count       = cnt_q;
  assign health_fail     = fail_q;

  rct_count_le_cutoff: assert property (@(posedge clk) disable iff (Reset)
    rct_count <= RCT_CW'(RCT_CUTOFF));

endmodule

// File: tb/tb_trng_entropy_collector.sv
module tb_trng_entropy_collector;
  import trng_entropy_collector_pkg::*;

  localparam int BW  = 512;
  localparam int DIV = 4;
  localparam int CUT = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                Reset;
  logic                enable;
  logic                raw_bit;
  logic                clear_fail;
  logic                health_fail;
  logic [$clog2(BW):0] bit_count;

  trng_entropy_collector_if #(.BLOCK_W(BW)) blk_if ();

  trng_entropy_collector #(
    .BLOCK_W    (BW),
    .SAMPLE_DIV (DIV),
    .RCT_CUTOFF (CUT)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .enable      (enable),
    .raw_bit     (raw_bit),
    .clear_fail  (clear_fail),
    .health_fail (health_fail),
    .bit_count   (bit_count),
    .blk         (blk_if.master)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;

  // Reference model of the debiaser; completed blocks go to the scoreboard.
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] m_blk = '0;
  logic          m_pair = 1'b0;
  logic          m_first = 1'b0;
  int            m_cnt = 0;

  task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_sample(input logic b);
    if (!m_pair) begin
      m_first = b;
      m_pair  = 1'b1;
    end else begin
      m_pair = 1'b0;
      if (m_first != b) begin
        m_blk = {m_blk[BW-2:0], m_first};
        m_cnt++;
        if (m_cnt == BW) begin
          exp_q.push_back(m_blk);
          m_cnt = 0;
        end
      end
    end
  endtask

  task automatic model_discard();
    m_pair = 1'b0;
    m_cnt  = 0;
  endtask

  // Hold one raw value for a full divider window, so it is sampled on the window's last edge.
  task automatic feed(input logic b);
    raw_bit = b;
    model_sample(b);
    repeat (DIV) tick();
  endtask

  // Transfer happens on the next edge whenever valid & ready are seen here.
  always @(negedge clk) begin
    if (!Reset && blk_if.block_valid && blk_if.block_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) check("sb_avail", {511'b0, exp_q.size() != 0}, 1);
      else                   check("sb_data", blk_if.block_data, exp_q.pop_front());
    end
  end

  initial begin
    logic [BW-1:0] ones;
    logic [BW-1:0] snap;
    logic [5:0]    pat;
    logic          b;
    logic          stable;
    int            xfer_before;

    ones = '1;
    pat  = 6'b100011;   // LSB first: 1,1,0,0,0,1
    Reset = 1'b1; enable = 1'b0; raw_bit = 1'b0; clear_fail = 1'b0;
    blk_if.block_ready = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    check("rst_valid", blk_if.block_valid, 0);
    check("rst_data",  blk_if.block_data, 0);
    check("rst_count", bit_count, 0);
    check("rst_fail",  health_fail, 0);

    // Alternating 1,0 -> every pair emits 1.
    blk_if.block_ready = 1'b1;
    enable = 1'b1;
    tick();
    for (int i = 0; i < 2 * BW; i++) feed(logic'(i % 2 == 0));
    check("t1_valid", blk_if.block_valid, 1);
    check("t1_count", bit_count, BW);
    check("t1_data",  blk_if.block_data, ones);
    check("t1_fail",  health_fail, 0);
    tick();
    check("t1_valid_after", blk_if.block_valid, 0);
    check("t1_count_after", bit_count, 0);

    // 11,00,01 repeated -> one 0 per six samples.
    for (int i = 0; i < 6 * BW; i++) begin
      feed(pat[i % 6]);
      if (i == 4) check("t2_count_5", bit_count, 0);
      if (i == 5) check("t2_count_6", bit_count, 1);
      if (i == 6 * BW - 2) check("t2_valid_early", blk_if.block_valid, 0);
    end
    check("t2_valid", blk_if.block_valid, 1);
    check("t2_data",  blk_if.block_data, 0);
    tick();
    check("t2_valid_after", blk_if.block_valid, 0);

    // Full block held under backpressure, then a single-cycle ready.
    blk_if.block_ready = 1'b0;
    for (int i = 0; i < BW; i++) begin
      b = 1'($urandom_range(0, 1));
      feed(b);
      feed(~b);
    end
    check("t4_valid", blk_if.block_valid, 1);
    check("t4_count", bit_count, BW);
    check("t4_data",  blk_if.block_data, exp_q[0]);
    snap   = blk_if.block_data;
    stable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      raw_bit = 1'($urandom);
      tick();
      if (blk_if.block_data !== snap || blk_if.block_valid !== 1'b1 || bit_count != BW)
        stable = 1'b0;
    end
    check("t4_hold", stable, 1);
    xfer_before = n_xfer;
    blk_if.block_ready = 1'b1;
    tick();
    blk_if.block_ready = 1'b0;
    check("t4_valid_after", blk_if.block_valid, 0);
    check("t4_count_after", bit_count, 0);
    check("t4_one_xfer", n_xfer, xfer_before + 1);

    // Reset mid-block, then a complete fresh block.
    blk_if.block_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      b = 1'($urandom_range(0, 1));
      feed(b);
      feed(~b);
    end
    check("t5_count_pre", bit_count, 300);
    Reset = 1'b1;
    tick();
    check("t5_rst_data",  blk_if.block_data, 0);
    check("t5_rst_valid", blk_if.block_valid, 0);
    check("t5_rst_count", bit_count, 0);
    check("t5_rst_fail",  health_fail, 0);
    Reset = 1'b0;
    model_discard();
    tick();
    for (int i = 0; i < BW; i++) begin
      b = 1'($urandom_range(0, 1));
      feed(b);
      feed(~b);
      if (i == BW - 2) begin
        check("t5_count_511", bit_count, BW - 1);
        check("t5_valid_511", blk_if.block_valid, 0);
      end
    end
    check("t5_valid", blk_if.block_valid, 1);
    check("t5_count", bit_count, BW);
    tick();

    // enable drop mid-block, then divider restart on re-enable.
    for (int i = 0; i < 100; i++) begin
      b = 1'($urandom_range(0, 1));
      feed(b);
      feed(~b);
    end
    check("t6_count_pre", bit_count, 100);
    repeat (2) tick();
    enable = 1'b0;
    tick();
    check("t6_count_idle", bit_count, 0);
    check("t6_valid_idle", blk_if.block_valid, 0);
    model_discard();
    repeat (3) tick();
    enable = 1'b1;
    tick();
    raw_bit = 1'b1;
    model_sample(1'b1);
    repeat (DIV) tick();
    raw_bit = 1'b0;
    model_sample(1'b0);
    repeat (DIV - 1) tick();
    check("t6_count_before_strobe", bit_count, 0);
    tick();
    check("t6_count_at_strobe", bit_count, 1);

    // Stuck source: RCT trips on the 32nd strobe.
    enable = 1'b0;
    tick();
    model_discard();
    clear_fail = 1'b1;
    tick();
    clear_fail = 1'b0;
    check("t3_fail_clr_idle", health_fail, 0);
    raw_bit = 1'b1;
    enable  = 1'b1;
    tick();
    repeat (DIV * CUT - 1) tick();
    check("t3_fail_early", health_fail, 0);
    tick();
    check("t3_fail", health_fail, 1);
    check("t3_count", bit_count, 0);
    check("t3_valid", blk_if.block_valid, 0);
    repeat (10) tick();
    check("t3_fail_sticky", health_fail, 1);
    check("t3_valid_sticky", blk_if.block_valid, 0);
    clear_fail = 1'b1;
    enable     = 1'b0;
    tick();
    clear_fail = 1'b0;
    check("t3_fail_cleared", health_fail, 0);
    enable = 1'b1;
    tick();
    feed(1'b1);
    feed(1'b0);
    check("t3_resume_count", bit_count, 1);

    check("sb_drain", exp_q.size(), 0);
    check("xfer_total", n_xfer, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
